// File: rtl/peripheral_spram_axi4_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_spram_axi4_scheduler_if
// Brief    : AXI4 request/data/response bundle between the bus and the scheduler
// Revision : 1.0
// ============================================================================
interface peripheral_spram_axi4_scheduler_if #(
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
   logic [AXI_ID_WIDTH-1:0]   axi_aw_id;
   logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr;
   logic [7:0]                axi_aw_len;
   logic                      axi_aw_valid;
   logic                      axi_aw_ready;
   logic [AXI_ID_WIDTH-1:0]   axi_ar_id;
   logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr;
   logic [7:0]                axi_ar_len;
   logic                      axi_ar_valid;
   logic                      axi_ar_ready;
   logic [AXI_DATA_WIDTH-1:0] axi_w_data;
   logic [AXI_STRB_WIDTH-1:0] axi_w_strb;
   logic                      axi_w_last;
   logic                      axi_w_valid;
   logic                      axi_w_ready;
   logic [AXI_ID_WIDTH-1:0]   axi_r_id;
   logic [AXI_DATA_WIDTH-1:0] axi_r_data;
   logic [1:0]                axi_r_resp;
   logic                      axi_r_last;
   logic                      axi_r_valid;
   logic                      axi_r_ready;
   logic [AXI_ID_WIDTH-1:0]   axi_b_id;
   logic [1:0]                axi_b_resp;
   logic                      axi_b_valid;
   logic                      axi_b_ready;

   modport slave (
      input  axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_valid,
      output axi_aw_ready,
      input  axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_valid,
      output axi_ar_ready,
      input  axi_w_data, axi_w_strb, axi_w_last, axi_w_valid,
      output axi_w_ready,
      output axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid,
      input  axi_r_ready,
      output axi_b_id, axi_b_resp, axi_b_valid,
      input  axi_b_ready
   );

   modport master (
      output axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_valid,
      input  axi_aw_ready,
      output axi_ar_id, axi_ar_addr, axi_ar_len, axi_ar_valid,
      input  axi_ar_ready,
      output axi_w_data, axi_w_strb, axi_w_last, axi_w_valid,
      input  axi_w_ready,
      input  axi_r_id, axi_r_data, axi_r_resp, axi_r_last, axi_r_valid,
      output axi_r_ready,
      input  axi_b_id, axi_b_resp, axi_b_valid,
      output axi_b_ready
   );
endinterface
`default_nettype wire

// File: rtl/peripheral_spram_axi4_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_spram_axi4_scheduler
// Brief    : Serialises AXI4 INCR bursts onto one SPRAM port, one access/cycle.
//            Optional macro SPRAM_AXI4_RANGE_CHECK_EN flags out-of-range bursts.
// Revision : 1.0
// ============================================================================
module peripheral_spram_axi4_scheduler #(
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
   parameter int RAM_ADDR_WIDTH = 10
) (
   input  wire logic                          clk_i,
   input  wire logic                          rst_i,
   peripheral_spram_axi4_scheduler_if.slave   axi,
   output logic                               ram_req_o,
   output logic                               ram_we_o,
   output logic [RAM_ADDR_WIDTH-1:0]          ram_addr_o,
   output logic [AXI_DATA_WIDTH-1:0]          ram_wdata_o,
   output logic [AXI_STRB_WIDTH-1:0]          ram_be_o,
   input  wire logic [AXI_DATA_WIDTH-1:0]     ram_rdata_i
);
   localparam int         ADDR_LSB    = $clog2(AXI_STRB_WIDTH);
   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WRESP = 3'd2,
      S_RREQ  = 3'd3,
      S_RLAT  = 3'd4,
      S_RDATA = 3'd5
   } state_t;

   state_t                    state_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [RAM_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]                len_q;
   logic [7:0]                cnt_q;
   logic [1:0]                resp_q;
   logic                      oor_q;
   logic [AXI_DATA_WIDTH-1:0] rdata_q;
   logic                      prio_wr_q;
   logic                      w_ready_q;
   logic                      b_valid_q;
   logic                      r_valid_q;
   logic                      r_last_q;

   logic w_grant_wr;
   logic w_grant_rd;
   logic w_aw_oor;
   logic w_ar_oor;
   logic w_beat_last;
   logic w_wr_beat;
   logic w_unused_addr;

`ifdef SPRAM_AXI4_RANGE_CHECK_EN
   assign w_aw_oor = |axi.axi_aw_addr[AXI_ADDR_WIDTH-1:RAM_ADDR_WIDTH+ADDR_LSB];
   assign w_ar_oor = |axi.axi_ar_addr[AXI_ADDR_WIDTH-1:RAM_ADDR_WIDTH+ADDR_LSB];
   assign w_unused_addr = ^{axi.axi_aw_addr[ADDR_LSB-1:0], axi.axi_ar_addr[ADDR_LSB-1:0]};
`else
   // Upper address bits alias modulo depth, so they are deliberately dropped.
   assign w_aw_oor = 1'b0;
   assign w_ar_oor = 1'b0;
   assign w_unused_addr = ^{axi.axi_aw_addr[AXI_ADDR_WIDTH-1:RAM_ADDR_WIDTH+ADDR_LSB],
                            axi.axi_aw_addr[ADDR_LSB-1:0],
                            axi.axi_ar_addr[AXI_ADDR_WIDTH-1:RAM_ADDR_WIDTH+ADDR_LSB],
                            axi.axi_ar_addr[ADDR_LSB-1:0]};
`endif

   // A tie goes to whichever channel was not granted last.
   assign w_grant_wr  = (state_q == S_IDLE) && axi.axi_aw_valid &&
                        (!axi.axi_ar_valid || prio_wr_q);
   assign w_grant_rd  = (state_q == S_IDLE) && axi.axi_ar_valid && !w_grant_wr;
   assign w_beat_last = (cnt_q == len_q);
   assign w_wr_beat   = (state_q == S_WRITE) && axi.axi_w_valid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         resp_q    <= RESP_OKAY;
         oor_q     <= 1'b0;
         rdata_q   <= '0;
         prio_wr_q <= 1'b1;
         w_ready_q <= 1'b0;
         b_valid_q <= 1'b0;
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_grant_wr) begin
                  id_q      <= axi.axi_aw_id;
                  addr_q    <= axi.axi_aw_addr[RAM_ADDR_WIDTH+ADDR_LSB-1:ADDR_LSB];
                  len_q     <= axi.axi_aw_len;
                  cnt_q     <= '0;
                  oor_q     <= w_aw_oor;
                  resp_q    <= w_aw_oor ? RESP_SLVERR : RESP_OKAY;
                  prio_wr_q <= 1'b0;
                  w_ready_q <= 1'b1;
                  state_q   <= S_WRITE;
               end else if (w_grant_rd) begin
                  id_q      <= axi.axi_ar_id;
                  addr_q    <= axi.axi_ar_addr[RAM_ADDR_WIDTH+ADDR_LSB-1:ADDR_LSB];
                  len_q     <= axi.axi_ar_len;
                  cnt_q     <= '0;
                  oor_q     <= w_ar_oor;
                  resp_q    <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
                  prio_wr_q <= 1'b1;
                  state_q   <= S_RREQ;
               end
            end
            S_WRITE: begin
               if (axi.axi_w_valid) begin
                  // The beat count, not w_last, terminates the burst.
                  if (axi.axi_w_last != w_beat_last) begin
                     resp_q <= RESP_SLVERR;
                  end
                  if (w_beat_last) begin
                     w_ready_q <= 1'b0;
                     b_valid_q <= 1'b1;
                     state_q   <= S_WRESP;
                  end else begin
                     cnt_q  <= cnt_q + 8'd1;
                     addr_q <= addr_q + 1'b1;
                  end
               end
            end
            S_WRESP: begin
               if (axi.axi_b_ready) begin
                  b_valid_q <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            S_RREQ: begin
               state_q <= S_RLAT;
            end
            S_RLAT: begin
               rdata_q   <= oor_q ? '0 : ram_rdata_i;
               r_valid_q <= 1'b1;
               r_last_q  <= w_beat_last;
               state_q   <= S_RDATA;
            end
            S_RDATA: begin
               if (axi.axi_r_ready) begin
                  r_valid_q <= 1'b0;
                  if (r_last_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q   <= cnt_q + 8'd1;
                     addr_q  <= addr_q + 1'b1;
                     state_q <= S_RREQ;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign axi.axi_aw_ready = w_grant_wr;
   assign axi.axi_ar_ready = w_grant_rd;
   assign axi.axi_w_ready  = w_ready_q;
   assign axi.axi_b_id     = id_q;
   assign axi.axi_b_resp   = resp_q;
   assign axi.axi_b_valid  = b_valid_q;
   assign axi.axi_r_id     = id_q;
   assign axi.axi_r_data   = rdata_q;
   assign axi.axi_r_resp   = resp_q;
   assign axi.axi_r_last   = r_last_q;
   assign axi.axi_r_valid  = r_valid_q;

   assign ram_we_o    = w_wr_beat && !oor_q;
   assign ram_req_o   = ram_we_o || ((state_q == S_RREQ) && !oor_q);
   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = ram_we_o ? axi.axi_w_data : '0;
   assign ram_be_o    = ram_we_o ? axi.axi_w_strb : '0;
endmodule
`default_nettype wire
